// File: rtl/modmul_arbiter.sv
// modmul_arbiter: two-requester front end for a shared, fully pipelined
// modular multiplier with a fixed latency.
//
// Each cycle it grants at most one requester and registers the granted
// operands onto mm_a/mm_b. A LATENCY-deep valid+id tag pipeline tracks the
// operands in flight, so each product on mm_c is routed back to the
// requester that issued it.
//
// Configuration macro: MODMUL_ARB_RR_EN
//   defined   : a tie goes to the requester not granted most recently
//   undefined : fixed priority, requester 0 always wins a tie
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_valid/_a/_b        request handshake and operands (in)
//   req{0,1}_ready              combinational grant, qualified by valid (out)
//   res{0,1}_valid, res_c       one-cycle result pulse and its product (out)
//   mm_a, mm_b                  registered operands to the multiplier (out)
//   mm_c                        product from the multiplier (in)
//   busy                        at least one product in flight (out)
module modmul_arbiter #(
   parameter int unsigned LATENCY = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [29:0] req0_a,
   input  logic [29:0] req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [29:0] req1_a,
   input  logic [29:0] req1_b,
   output logic        req1_ready,
   output logic        res0_valid,
   output logic        res1_valid,
   output logic [29:0] res_c,
   output logic [29:0] mm_a,
   output logic [29:0] mm_b,
   input  logic [29:0] mm_c,
   output logic        busy
);

   localparam int unsigned DATA_W = 30;
   localparam int unsigned CNT_W  = 7;

   logic              gnt0_c;
   logic              gnt1_c;
   logic              hs0;
   logic              hs1;
   logic              issue;
   logic [DATA_W-1:0] mm_a_q;
   logic [DATA_W-1:0] mm_b_q;
   logic [LATENCY-1:0] vld_q;
   logic [LATENCY-1:0] id_q;
   logic              exit_vld;
   logic              exit_id;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

`ifdef MODMUL_ARB_RR_EN
   // Requester that won the most recent handshake (1 = requester 1).
   logic last_q;
   logic last_d;

   // Round-robin tie break against the last winner.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt0_c = last_q;
         gnt1_c = !last_q;
      end else begin
         gnt0_c = req0_valid;
         gnt1_c = req1_valid;
      end
   end

   // Pointer moves only on a handshake.
   always_comb begin
      last_d = last_q;
      if (hs0) begin
         last_d = 1'b0;
      end else if (hs1) begin
         last_d = 1'b1;
      end
   end

   // Reset to requester 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: requester 0 always wins.
   always_comb begin
      gnt0_c = req0_valid;
      gnt1_c = req1_valid && !req0_valid;
   end
`endif

   // Grants are suppressed while reset is held.
   assign req0_ready = rst_n && gnt0_c;
   assign req1_ready = rst_n && gnt1_c;
   assign hs0        = req0_valid && req0_ready;
   assign hs1        = req1_valid && req1_ready;
   assign issue      = hs0 || hs1;

   // Operand registers: load on handshake, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mm_a_q <= '0;
         mm_b_q <= '0;
      end else if (hs0) begin
         mm_a_q <= req0_a;
         mm_b_q <= req0_b;
      end else if (hs1) begin
         mm_a_q <= req1_a;
         mm_b_q <= req1_b;
      end
   end

   assign mm_a = mm_a_q;
   assign mm_b = mm_b_q;

   // Tag pipeline: never stalls, so the tag leaving the last stage lines up
   // with the product the multiplier presents on mm_c in that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         id_q  <= '0;
      end else begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            vld_q[i] <= vld_q[i-1];
            id_q[i]  <= id_q[i-1];
         end
         vld_q[0] <= issue;
         id_q[0]  <= hs1;
      end
   end

   assign exit_vld   = vld_q[LATENCY-1];
   assign exit_id    = id_q[LATENCY-1];
   assign res0_valid = exit_vld && !exit_id;
   assign res1_valid = exit_vld && exit_id;
   assign res_c      = exit_vld ? mm_c : '0;

   // In-flight count; bounded by LATENCY because the pipeline has that many slots.
   always_comb begin
      cnt_d = cnt_q;
      if (issue && !exit_vld) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!issue && exit_vld) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (cnt_q != '0);

endmodule
